// File: rtl/dcpu_perf_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dcpu_perf_pkg
//  Brief    : Shared encodings for the dcpu performance monitor: FSM states,
//             readout select codes, counter slot indices, stream constants.
//  Revision : 1.0 - initial release
// ============================================================================
package dcpu_perf_pkg;

    // Monitor states; the encoding is visible on the state port and in the
    // status readout word.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Readout select codes; values 6 and 7 read as zero.
    localparam logic [2:0] SEL_CYCLE  = 3'd0;
    localparam logic [2:0] SEL_NOP    = 3'd1;
    localparam logic [2:0] SEL_INSTR  = 3'd2;
    localparam logic [2:0] SEL_STALL  = 3'd3;
    localparam logic [2:0] SEL_REDIR  = 3'd4;
    localparam logic [2:0] SEL_STATUS = 3'd5;

    // Slot of each event counter in the counter bank.
    localparam int CNT_CYCLE = 0;
    localparam int CNT_NOP   = 1;
    localparam int CNT_INSTR = 2;
    localparam int CNT_STALL = 3;
    localparam int CNT_REDIR = 4;
    localparam int NUM_CNT   = 5;

    // An all-zero instruction word is a bubble; sequential flow steps by 4.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage
`default_nettype wire

// File: rtl/dcpu_perf_mon_if.sv
`default_nettype none
// ============================================================================
//  Module   : dcpu_perf_mon_if
//  Brief    : Sample stream, control and readout bundle of the performance
//             monitor. The stream source / host side is the master.
//  Revision : 1.0 - initial release
// ============================================================================
interface dcpu_perf_mon_if;

    logic        en;
    logic        clr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  sel;
    logic [31:0] rdata;
    logic [1:0]  state;
    logic        halted;
    logic        overflow;

    modport master (
        output en, clr, instr, pc, sel,
        input  rdata, state, halted, overflow
    );

    modport slave (
        input  en, clr, instr, pc, sel,
        output rdata, state, halted, overflow
    );

endinterface
`default_nettype wire

// File: rtl/dcpu_perf_mon_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Brief    : W-bit event counter that sticks at all-ones. sat reports the
//             counter is full so the parent can flag a lost increment.
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         clr,
    input  wire logic         inc,
    output logic [W-1:0]      q,
    output logic              sat
);

    logic [W-1:0] r_q;

    assign q   = r_q;
    assign sat = &r_q;

    // Count up on inc unless already full; clear wins over inc.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && !sat) begin
            r_q <= r_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcpu_perf_mon.sv
`default_nettype none
// ============================================================================
//  Module   : dcpu_perf_mon
//  Brief    : Performance monitor on the committed instr/pc stream. Counts
//             cycles, NOPs, instructions, stalls and redirects, detects a
//             stuck PC as halt, and offers one counter on a registered port.
//  Revision : 1.0 - initial release
// ============================================================================
module dcpu_perf_mon
    import dcpu_perf_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int HALT_CYC = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    dcpu_perf_mon_if.slave   bus
);

    localparam int c_run_w = $clog2(HALT_CYC + 1);
    localparam int c_ext_w = (CNT_W > 32) ? CNT_W : 32;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [31:0]        r_prev_pc;
    logic               r_prev_valid;
    logic [c_run_w-1:0] r_run;
    logic               r_overflow;
    logic [31:0]        r_rdata;

    logic               w_count;
    logic               w_halt_exit;
    logic               w_same_pc;
    logic               w_seq_pc;
    logic               w_run_last;
    logic [NUM_CNT-1:0] w_inc;
    logic [NUM_CNT-1:0] w_sat;
    logic [CNT_W-1:0]   w_cnt [NUM_CNT];
    logic [31:0]        w_sel_val;

    // Zero-extend or truncate a counter value to the 32-bit readout.
    function automatic logic [31:0] fit32(input logic [CNT_W-1:0] v);
        logic [c_ext_w-1:0] t;
        t = c_ext_w'(v);
        return t[31:0];
    endfunction

    assign w_same_pc  = (bus.pc == r_prev_pc);
    assign w_seq_pc   = (bus.pc == r_prev_pc + PC_STEP);
    // This stall completes the run of equal PCs that declares a halt.
    assign w_run_last = ((int'(r_run) + 1) == HALT_CYC);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle sampling decisions; clr overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_count     = 1'b0;
        w_halt_exit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.en) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.en) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_count = 1'b1;
                    if (r_prev_valid && w_same_pc && w_run_last) begin
                        w_state_nxt = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (!bus.en) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_same_pc) begin
                    w_state_nxt = ST_RUN;
                    w_halt_exit = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (bus.clr) begin
            w_state_nxt = ST_IDLE;
            w_count     = 1'b0;
            w_halt_exit = 1'b0;
        end
    end

    // Event classification of the sampled cycle.
    assign w_inc[CNT_CYCLE] = w_count;
    assign w_inc[CNT_NOP]   = w_count && (bus.instr == NOP_INSTR);
    assign w_inc[CNT_INSTR] = w_count && (bus.instr != NOP_INSTR);
    assign w_inc[CNT_STALL] = w_count && r_prev_valid && w_same_pc;
    assign w_inc[CNT_REDIR] = w_count && r_prev_valid && !w_same_pc && !w_seq_pc;

    generate
        for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
            sat_counter #(
                .W (CNT_W)
            ) u_cnt (
                .clk (clk),
                .rst (rst),
                .clr (bus.clr),
                .inc (w_inc[i]),
                .q   (w_cnt[i]),
                .sat (w_sat[i])
            );
        end
    endgenerate

    // PC history, stall run length and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev_pc    <= '0;
            r_prev_valid <= 1'b0;
            r_run        <= '0;
            r_overflow   <= 1'b0;
        end else if (bus.clr) begin
            r_prev_valid <= 1'b0;
            r_run        <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (|(w_inc & w_sat)) begin
                r_overflow <= 1'b1;
            end
            if (w_count) begin
                r_prev_pc    <= bus.pc;
                r_prev_valid <= 1'b1;
                r_run        <= (r_prev_valid && w_same_pc) ? r_run + 1'b1 : '0;
            end else if (w_halt_exit) begin
                // Resume from the new PC so the next cycle classifies
                // against it.
                r_prev_pc    <= bus.pc;
                r_prev_valid <= 1'b1;
                r_run        <= '0;
            end else if (!bus.en) begin
                r_prev_valid <= 1'b0;
                r_run        <= '0;
            end
        end
    end

    // Readout source selection.
    always_comb begin
        w_sel_val = '0;
        case (bus.sel)
            SEL_CYCLE:  w_sel_val = fit32(w_cnt[CNT_CYCLE]);
            SEL_NOP:    w_sel_val = fit32(w_cnt[CNT_NOP]);
            SEL_INSTR:  w_sel_val = fit32(w_cnt[CNT_INSTR]);
            SEL_STALL:  w_sel_val = fit32(w_cnt[CNT_STALL]);
            SEL_REDIR:  w_sel_val = fit32(w_cnt[CNT_REDIR]);
            SEL_STATUS: w_sel_val = {28'b0, r_state, 1'b0, r_overflow};
            default:    w_sel_val = '0;
        endcase
    end

    // Registered readout, one cycle behind sel.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_sel_val;
        end
    end

    assign bus.rdata    = r_rdata;
    assign bus.state    = r_state;
    assign bus.halted   = (r_state == ST_HALT);
    assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_dcpu_perf_mon.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcpu_perf_mon
//  Brief    : Directed self-checking bench for dcpu_perf_mon. A 32-bit and a
//             4-bit counter instance share the same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dcpu_perf_mon;
    import dcpu_perf_pkg::*;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        en    = 1'b0;
    logic        clr   = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] pc    = '0;
    logic [2:0]  sel   = '0;

    int n_chk  = 0;
    int n_fail = 0;

    dcpu_perf_mon_if bus_a ();
    dcpu_perf_mon_if bus_s ();

    assign bus_a.en    = en;
    assign bus_a.clr   = clr;
    assign bus_a.instr = instr;
    assign bus_a.pc    = pc;
    assign bus_a.sel   = sel;
    assign bus_s.en    = en;
    assign bus_s.clr   = clr;
    assign bus_s.instr = instr;
    assign bus_s.pc    = pc;
    assign bus_s.sel   = sel;

    // 100 MHz clock.
    always #5 clk = ~clk;

    dcpu_perf_mon #(
        .CNT_W    (32),
        .HALT_CYC (16)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    dcpu_perf_mon #(
        .CNT_W    (4),
        .HALT_CYC (16)
    ) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] p, input logic [31:0] i);
        pc    = p;
        instr = i;
        step();
    endtask

    task automatic rd(input logic [2:0] s);
        sel = s;
        step();
    endtask

    // Hard stop should the sequence ever stall.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] br_pc [6];

    initial begin
        br_pc = '{32'd0, 32'd4, 32'd4, 32'd4, 32'd40, 32'd44};

        // Reset held for two edges.
        rst = 1'b0;
        step();
        step();
        chk("rst_state",  32'(bus_a.state),    32'd0);
        chk("rst_rdata",  bus_a.rdata,         32'd0);
        chk("rst_halted", 32'(bus_a.halted),   32'd0);
        chk("rst_ovf",    32'(bus_a.overflow), 32'd0);

        // Idle: stream toggles but nothing may be counted.
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(32'(i * 8), 32'hA5A5_0000 + 32'(i));
        end
        for (int s = 0; s < 8; s++) begin
            rd(3'(s));
            chk($sformatf("idle_sel%0d", s), bus_a.rdata, 32'd0);
        end
        chk("idle_state", 32'(bus_a.state), 32'd0);

        // Linear stream of 10 with 3 bubbles.
        en = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            drive(32'(4 * i), (i == 1 || i == 4 || i == 7) ? 32'h0 : 32'h13 + 32'(i));
        end
        chk("lin_state", 32'(bus_a.state), 32'd1);
        en = 1'b0;
        step();
        rd(SEL_CYCLE); chk("lin_cycle", bus_a.rdata, 32'd10);
        rd(SEL_NOP);   chk("lin_nop",   bus_a.rdata, 32'd3);
        rd(SEL_INSTR); chk("lin_instr", bus_a.rdata, 32'd7);
        rd(SEL_STALL); chk("lin_stall", bus_a.rdata, 32'd0);
        rd(SEL_REDIR); chk("lin_redir", bus_a.rdata, 32'd0);
        rd(3'd7);      chk("lin_sel7",  bus_a.rdata, 32'd0);

        // Branch and stall stream.
        clr = 1'b1; step(); clr = 1'b0;
        en = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            drive(br_pc[i], 32'h13);
        end
        chk("br_state", 32'(bus_a.state), 32'd1);
        en = 1'b0;
        step();
        rd(SEL_CYCLE); chk("br_cycle", bus_a.rdata, 32'd6);
        rd(SEL_STALL); chk("br_stall", bus_a.rdata, 32'd2);
        rd(SEL_REDIR); chk("br_redir", bus_a.rdata, 32'd1);
        rd(SEL_INSTR); chk("br_instr", bus_a.rdata, 32'd6);

        // Halt on a PC held at 8: the 17th sampled cycle is the 16th stall.
        clr = 1'b1; step(); clr = 1'b0;
        en = 1'b1;
        step();
        for (int k = 1; k <= 20; k++) begin
            drive(32'd8, 32'h13);
            if (k == 16) chk("halt_pre", 32'(bus_a.halted), 32'd0);
            if (k == 17) chk("halt_set", 32'(bus_a.halted), 32'd1);
        end
        rd(SEL_STALL);  chk("halt_stall",  bus_a.rdata, 32'd16);
        rd(SEL_CYCLE);  chk("halt_cycle",  bus_a.rdata, 32'd17);
        rd(SEL_STATUS); chk("halt_status", bus_a.rdata, 32'h8);
        chk("halt_state", 32'(bus_a.state), 32'd2);
        drive(32'd12, 32'h13);
        chk("unhalt_state",  32'(bus_a.state),  32'd1);
        chk("unhalt_halted", 32'(bus_a.halted), 32'd0);
        drive(32'd16, 32'h13);
        en = 1'b0;
        step();
        rd(SEL_CYCLE); chk("resume_cycle", bus_a.rdata, 32'd18);
        rd(SEL_STALL); chk("resume_stall", bus_a.rdata, 32'd16);
        rd(SEL_REDIR); chk("resume_redir", bus_a.rdata, 32'd0);

        // Saturation of the 4-bit instance over 20 sampled cycles.
        clr = 1'b1; step(); clr = 1'b0;
        en = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            drive(32'(4 * i), 32'h13);
        end
        en = 1'b0;
        step();
        rd(SEL_CYCLE);
        chk("sat_cycle",  bus_s.rdata, 32'd15);
        chk("wide_cycle", bus_a.rdata, 32'd20);
        chk("sat_ovf",  32'(bus_s.overflow), 32'd1);
        chk("wide_ovf", 32'(bus_a.overflow), 32'd0);
        rd(SEL_STATUS); chk("sat_status", bus_s.rdata, 32'h1);
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_ovf",   32'(bus_s.overflow), 32'd0);
        chk("clr_state", 32'(bus_s.state),    32'd0);
        rd(SEL_CYCLE); chk("clr_cycle", bus_s.rdata, 32'd0);
        rd(SEL_INSTR); chk("clr_instr", bus_s.rdata, 32'd0);

        // clr together with en from RUN.
        en = 1'b1;
        step();
        drive(32'd100, 32'h13);
        drive(32'd104, 32'h13);
        clr = 1'b1;
        step();
        clr = 1'b0;
        en  = 1'b0;
        chk("clr_en_state", 32'(bus_a.state), 32'd0);
        rd(SEL_CYCLE); chk("clr_en_cycle", bus_a.rdata, 32'd0);

        // Reset while halted.
        en = 1'b1;
        step();
        for (int k = 0; k < 17; k++) begin
            drive(32'd20, 32'h13);
        end
        chk("rh_halted", 32'(bus_a.halted), 32'd1);
        rd(SEL_CYCLE); chk("rh_cycle", bus_a.rdata, 32'd17);
        rst = 1'b0;
        step();
        chk("rh_state",  32'(bus_a.state),  32'd0);
        chk("rh_rdata",  bus_a.rdata,       32'd0);
        chk("rh_halted2", 32'(bus_a.halted), 32'd0);
        rst = 1'b1;
        en  = 1'b0;
        rd(SEL_CYCLE); chk("rh_cycle0", bus_a.rdata, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcpu_perf_mon.md
Name: dcpu_perf_mon

Overview:
Cycle-accurate performance monitor that sits directly downstream of dcpu_top. It samples the committed instruction/PC stream (instr, pc) every clock and classifies each cycle. It accumulates cycle, NOP, instruction, stall and redirect counts, detects CPU halt (PC stuck), and exposes one selected counter on a registered readout port, so benches and the board wrapper need no ad-hoc counting.

Parameters:
CNT_W, 32, width of every event counter (saturating)
HALT_CYC, 16, consecutive equal-PC cycles that declare a halt (>=2)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-low reset (0 = reset)
en  input  1  count enable; 1 = monitor active
clr  input  1  synchronous clear of counters/flags, one cycle pulse
instr  input  32  instruction from dcpu_top, 32'h0 = NOP/bubble
pc  input  32  PC from dcpu_top
sel  input  3  counter select: 0 cycle, 1 nop, 2 instr, 3 stall, 4 redirect, 5 {state, overflow}, 6-7 zero
rdata  output  32  registered selected value, zero-extended/truncated to 32
state  output  2  0 IDLE, 1 RUN, 2 HALT
halted  output  1  1 while state==HALT
overflow  output  1  sticky: any counter saturated

Behaviour:
- Reset (rst==0 at posedge): all counters 0, run-length 0, prev_valid 0, prev_pc 0, state IDLE, rdata 0, overflow 0. Reset dominates clr/en.
- clr==1 (rst==1): counters, run-length, overflow, prev_valid -> 0; state -> IDLE; no counting that cycle. clr beats en.
- IDLE: nothing counted. en==1 -> RUN next cycle; first sampled cycle is that RUN cycle.
- RUN, en==1, each posedge:
  - cycle_cnt+1; instr==0 ? nop_cnt+1 : instr_cnt+1.
  - if prev_valid: pc==prev_pc -> stall_cnt+1, run+1; else pc!=prev_pc+4 (mod 2^32) -> redirect_cnt+1, run=0; else run=0.
  - prev_pc<=pc, prev_valid<=1. First cycle after IDLE/HALT-exit (prev_valid 0) does no stall/redirect classification.
  - stall cycle where run+1==HALT_CYC -> state HALT next cycle (that cycle still counted).
  - en==0 -> IDLE next cycle, current cycle not counted, counters hold, prev_valid->0.
- HALT: counters frozen. pc!=prev_pc -> RUN next cycle, prev_pc<=pc, run=0, prev_valid 1, that cycle not counted. en==0 -> IDLE.
- Saturation: a counter at 2^CNT_W-1 holds; a would-be increment sets overflow (sticky until clr/reset).
- rdata: registered mux of sel and counter values as of previous edge; 1-cycle latency from sel change. sel 5 -> {28'b0, state, 1'b0, overflow}.
- halted combinational from state register.

Decomposition:
- Package dcpu_perf_pkg: state encoding constants (ST_IDLE/ST_RUN/ST_HALT), sel codes, NOP_INSTR = 32'h0, PC_STEP = 4.
- Sub-module sat_counter (params W; ports clk, rst, clr, inc, q, sat) instantiated five times; FSM, PC compare and readout mux in top.

Test Plan:
- Reset/idle: rst low 2 cycles, en=0, toggle instr/pc 10 cycles -> all sel reads 0, state 0.
- Linear stream: en=1, pc 0,4,...,36 with instr 0 at 3 of the 10 -> cycle 10, nop 3, instr 7, stall 0, redirect 0.
- Branch/stall: pc 0,4,4,4,40,44 -> stall 2, redirect 1, cycle 6, state stays RUN.
- Halt: pc held at 8 for 20 cycles, HALT_CYC=16 -> halted 1 after 16th equal-PC cycle, stall frozen at 16, cycle frozen; pc->12 -> RUN next cycle, counting resumes next edge.
- Saturation: CNT_W=4, run 20 cycles -> cycle_cnt 15, overflow 1; clr pulse -> all 0, overflow 0, state IDLE.
- Priority: clr and en high together -> counters 0, state IDLE; rst low mid-HALT -> state 0, rdata 0 next edge.
